hilo_muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage of the MIPS datapath, instantiated inside TopLevel.
- Executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers, and services MTHI/MTLO writes.
- Raises Busy so the hazard logic stalls MFHI/MFLO and further mult/div issue until the result lands.

---
 rtl/hilo_muldiv_unit.sv | 202 ++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Multi-cycle multiply/divide unit for the EX stage. Runs MULT, MULTU,
//   DIV and DIVU into the architectural HI/LO registers, one iteration per
//   clock, and services MTHI/MTLO writes while idle.
//
// Ports
//   Clk, Rst        clock, asynchronous active-high reset
//   Start           one-cycle issue strobe (accepted only while idle)
//   Op              00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B            rs / rt operands
//   Flush           abort the in-flight operation; beats a same-cycle Start
//   HiWrite,LoWrite MTHI / MTLO strobes, data on WData, ignored while busy
//   Busy            operation in flight (RUN or FIX)
//   Done            one-cycle pulse in the cycle Hi/Lo show a mult/div result
//   Hi, Lo          architectural HI / LO
//   dbg_state       current FSM state for observation
//
// Handshake: Start is a single-cycle request with no ready return; it is
// taken only when Busy=0 and Flush=0, otherwise it is silently dropped.
// Timing: Start sampled at edge E0 -> RUN from E0 to E32 (WIDTH iterations),
// FIX for the cycle after E32, Hi/Lo written and Done=1 after E33.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    count;
  logic             is_div;
  logic             is_signed;
  logic             neg_a;
  logic             neg_b;
  logic             div_zero;
  logic [WIDTH-1:0] orig_a;   // dividend as issued, returned in Hi on divide by zero
  logic [WIDTH-1:0] op_b;     // multiplicand (mult) or divisor (div), magnitude
  logic [WIDTH-1:0] acc_hi;   // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier bits / dividend bits then quotient
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  // Operand magnitudes at issue time; unsigned ops pass through untouched.
  logic             sgn_op;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  assign sgn_op = ~Op[0];
  assign abs_a  = (sgn_op && A[WIDTH-1]) ? -A : A;
  assign abs_b  = (sgn_op && B[WIDTH-1]) ? -B : B;

  // One shift-add step: add multiplicand when the current multiplier bit is
  // set, then shift the whole {carry, hi, lo} right by one.
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_shift;
  assign add_sum   = {1'b0, acc_hi} + {1'b0, op_b};
  assign mul_shift = acc_lo[0] ? {add_sum, acc_lo[WIDTH-1:1]}
                               : {1'b0, acc_hi, acc_lo[WIDTH-1:1]};

  // One restoring-divide step. Since remainder < divisor, the shifted value
  // minus the divisor always fits WIDTH bits when non-negative, so bit WIDTH
  // of the trial is a clean borrow flag.
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] trial;
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign trial     = div_shift - {1'b0, op_b};

  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;
  always_comb begin
    iter_hi = mul_shift[2*WIDTH-1:WIDTH];
    iter_lo = mul_shift[WIDTH-1:0];
    if (is_div) begin
      if (!trial[WIDTH]) begin
        iter_hi = trial[WIDTH-1:0];
        iter_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        iter_hi = div_shift[WIDTH-1:0];
        iter_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign correction: product and quotient negate when operand signs differ,
  // remainder takes the dividend's sign.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  assign prod = {acc_hi, acc_lo};
  always_comb begin
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (!is_div) begin
      if (is_signed && (neg_a ^ neg_b)) begin
        fix_hi = (-prod) >> WIDTH;
        fix_lo = WIDTH'(-prod);
      end
    end else if (div_zero) begin
      fix_hi = orig_a;
      fix_lo = '1;
    end else begin
      fix_hi = (is_signed && neg_a)           ? -acc_hi : acc_hi;
      fix_lo = (is_signed && (neg_a ^ neg_b)) ? -acc_lo : acc_lo;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Start && !Flush) state_nx = RUN;
      RUN:     if (Flush) state_nx = IDLE;
               else if (count == CW'(WIDTH - 1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      count     <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      div_zero  <= 1'b0;
      orig_a    <= '0;
      op_b      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state == FIX) && !Flush;
      case (state)
        IDLE: begin
          if (Start && !Flush) begin
            count     <= '0;
            is_div    <= Op[1];
            is_signed <= sgn_op;
            neg_a     <= sgn_op & A[WIDTH-1];
            neg_b     <= sgn_op & B[WIDTH-1];
            div_zero  <= (B == '0);
            orig_a    <= A;
            acc_hi    <= '0;
            acc_lo    <= Op[1] ? abs_a : abs_b;
            op_b      <= Op[1] ? abs_b : abs_a;
          end else if (!Start) begin
            // A same-cycle Start (even a flushed one) drops MTHI/MTLO.
            if (HiWrite) hi_q <= WData;
            if (LoWrite) lo_q <= WData;
          end
        end
        RUN: begin
          if (!Flush) begin
            count  <= count + 1'b1;
            acc_hi <= iter_hi;
            acc_lo <= iter_lo;
          end
        end
        FIX: begin
          if (!Flush) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy      = (state != IDLE);
  assign Done      = done_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed cases plus randomized operations
// checked against a plain-arithmetic reference model and an expected queue.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         Start = 1'b0;
  logic [1:0]   Op = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Flush = 1'b0;
  logic         HiWrite = 1'b0;
  logic         LoWrite = 1'b0;
  logic [W-1:0] WData = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] exp_q[$];

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .Flush(Flush), .HiWrite(HiWrite), .LoWrite(LoWrite), .WData(WData),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: returns {hi, lo} ----------------
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    case (op)
      2'b00: begin sp = sa * sb; res = sp; end
      2'b01: begin up = ua * ub; res = up; end
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (op == 2'b10) begin
          sq = sa / sb;   // truncates toward zero
          sr = sa % sb;   // sign follows the dividend
          res = {sr[31:0], sq[31:0]};
        end else begin
          res = {32'(ua % ub), 32'(ua / ub)};
        end
      end
    endcase
    return res;
  endfunction

  // ---------------- driver ----------------
  // Issues one operation, waits (bounded) for Done, checks busy length and
  // the result against the head of the expected queue. With disturb set, a
  // second Start plus MTHI/MTLO are driven mid-operation and must be ignored.
  // Returns in the Done cycle, so a following call issues in that cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb);
    int             busy_n;
    bit             seen;
    logic [2*W-1:0] exp;
    exp_q.push_back(model(op, a, b));
    Op = op; A = a; B = b; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    busy_n = 0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (Done) begin
        seen = 1'b1;
        break;
      end
      if (Busy) busy_n++;
      Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
      if (disturb && i == 5) begin
        Start = 1'b1; Op = 2'b11; A = $urandom; B = $urandom;
        HiWrite = 1'b1; LoWrite = 1'b1; WData = 32'h1;
      end
      @(posedge Clk); #1;
    end
    Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    check({tag, "_done"}, 64'(seen), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
    check({tag, "_busy_in_done"}, 64'(Busy), 64'd0);
    exp = exp_q.pop_front();
    check({tag, "_hi"}, 64'(Hi), 64'(exp[63:32]));
    check({tag, "_lo"}, 64'(Lo), 64'(exp[31:0]));
  endtask

  task automatic mt_write(input bit hw, input bit lw, input logic [31:0] d);
    HiWrite = hw; LoWrite = lw; WData = d;
    @(posedge Clk); #1;
    HiWrite = 1'b0; LoWrite = 1'b0;
  endtask

  // Counts Done pulses over a window; used after aborts.
  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (Done) n++;
      @(posedge Clk); #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          nd;
    logic [1:0]  rop;
    logic [31:0] ra, rb, rd;

    // reset state
    #1;
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_hi", 64'(Hi), 64'd0);
    check("rst_lo", 64'(Lo), 64'd0);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(posedge Clk); #1;

    // directed operations
    run_op("multu_ff_x2", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    check("multu_hi_const", 64'(Hi), 64'h0000_0001);
    check("multu_lo_const", 64'(Lo), 64'hFFFF_FFFE);
    @(posedge Clk); #1;
    check("done_single_pulse", 64'(Done), 64'd0);
    run_op("mult_m3_x7", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    check("mult_lo_const", 64'(Lo), 64'hFFFF_FFEB);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    check("div_lo_const", 64'(Lo), 64'hFFFF_FFFD);
    check("div_hi_const", 64'(Hi), 64'hFFFF_FFFF);
    run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo", 64'(Lo), 64'h8000_0000);
    check("div_ovf_hi", 64'(Hi), 64'h0);
    run_op("divu_by0", 2'b11, 32'h0000_1234, 32'h0, 1'b0);
    check("divu0_lo", 64'(Lo), 64'hFFFF_FFFF);
    check("divu0_hi", 64'(Hi), 64'h0000_1234);
    run_op("div_by0", 2'b10, 32'h0000_1234, 32'h0, 1'b0);
    run_op("div_neg_by0", 2'b10, 32'hFFFF_0000, 32'h0, 1'b0);

    // ignored Start/MTHI/MTLO while busy; back-to-back issue in the Done cycle
    run_op("disturbed", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    run_op("issue_in_done", 2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    @(posedge Clk); #1;

    // MTHI / MTLO preload, then flush mid-run
    mt_write(1'b1, 1'b0, 32'hAAAA_0000);
    mt_write(1'b0, 1'b1, 32'h0000_5555);
    check("mthi", 64'(Hi), 64'hAAAA_0000);
    check("mtlo", 64'(Lo), 64'h0000_5555);
    Op = 2'b01; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (9) begin @(posedge Clk); #1; end
    check("flush_busy_before", 64'(Busy), 64'd1);
    Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    check("flush_busy_after", 64'(Busy), 64'd0);
    count_done(40, nd);
    check("flush_no_done", 64'(nd), 64'd0);
    check("flush_hi_kept", 64'(Hi), 64'hAAAA_0000);
    check("flush_lo_kept", 64'(Lo), 64'h0000_5555);

    // Flush in idle beats a same-cycle Start
    Op = 2'b01; A = 32'd3; B = 32'd4; Start = 1'b1; Flush = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; Flush = 1'b0;
    check("flush_beats_start", 64'(Busy), 64'd0);

    // Start beats a same-cycle MTHI
    Op = 2'b01; A = 32'd3; B = 32'd4; Start = 1'b1; HiWrite = 1'b1; WData = 32'hDEAD_BEEF;
    @(posedge Clk); #1;
    Start = 1'b0; HiWrite = 1'b0;
    check("start_beats_mthi_busy", 64'(Busy), 64'd1);
    check("start_beats_mthi_hi", 64'(Hi), 64'hAAAA_0000);
    for (int i = 0; i < 60 && !Done; i++) begin @(posedge Clk); #1; end
    check("start_beats_mthi_res_lo", 64'(Lo), 64'd12);
    check("start_beats_mthi_res_hi", 64'(Hi), 64'd0);

    // reset mid-run
    mt_write(1'b1, 1'b1, 32'h0BAD_F00D);
    Op = 2'b00; A = 32'h1357_9BDF; B = 32'h2468_ACE0; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) begin @(posedge Clk); #1; end
    Rst = 1'b1;
    #1;
    check("midrst_busy", 64'(Busy), 64'd0);
    check("midrst_hi", 64'(Hi), 64'd0);
    check("midrst_lo", 64'(Lo), 64'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    count_done(40, nd);
    check("midrst_no_done", 64'(nd), 64'd0);

    // randomized operations and MTHI/MTLO
    for (int k = 0; k < 16; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", k), rop, ra, rb, 1'b0);
      if (k % 4 == 3) begin
        rd = $urandom;
        mt_write(1'b1, 1'b1, rd);
        check($sformatf("rand_mt_hi%0d", k), 64'(Hi), 64'(rd));
        check($sformatf("rand_mt_lo%0d", k), 64'(Lo), 64'(rd));
      end
    end

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
